// File: rtl/uart_fifo_tx_if.sv
// Byte-push and status bundle of the buffered UART transmitter.
// The producer side uses the master modport and the transmitter uses the slave modport.
interface uart_fifo_tx_if #(
  parameter int FIFO_AW = 4
);
  logic               Wr_En;
  logic [7:0]         Wr_Data;
  logic               Full;
  logic               Empty;
  logic [FIFO_AW:0]   Level;
  logic               Overflow;
  logic               Rs232_Tx;
  logic               Tx_Busy;
  logic               Tx_Done;

  modport master (
    output Wr_En, Wr_Data,
    input  Full, Empty, Level, Overflow, Rs232_Tx, Tx_Busy, Tx_Done
  );

  modport slave (
    input  Wr_En, Wr_Data,
    output Full, Empty, Level, Overflow, Rs232_Tx, Tx_Busy, Tx_Done
  );
endinterface

// File: rtl/uart_fifo_tx.sv
// Buffered UART transmitter: a 2^FIFO_AW byte FIFO drained by an 8-bit serializer
// with a programmable baud divisor, optional parity and one or two stop bits.
// Every output, including the serial line, comes straight from a flop.
module uart_fifo_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_AW    = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             CLK,
  input  logic             RST,
  uart_fifo_tx_if.slave    bus
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  localparam int                 BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]      BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0]   DEPTH_L   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LEVEL_0   = {(FIFO_AW + 1){1'b0}};
  localparam logic [2:0]         STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic               PE_BIT    = 1'(PARITY_EN);
  localparam logic               ODD_BIT   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity of a byte, inverted for odd parity so the frame's total ones count matches the mode.
  function automatic logic parity_bit(input logic [7:0] data);
    parity_bit = (^data) ^ ODD_BIT;
  endfunction

  logic [7:0]         mem [DEPTH];

  state_t             state_q,  state_d;
  logic [BW-1:0]      baud_q,   baud_d;
  logic [2:0]         bit_q,    bit_d;
  logic [7:0]         shift_q,  shift_d;
  logic               par_q,    par_d;
  logic               tx_q,     tx_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q,  count_d;
  logic               full_q,   full_d;
  logic               empty_q,  empty_d;
  logic               ovf_q,    ovf_d;

  logic               push_s;
  logic               pop_s;
  logic               bit_end_s;
  logic [7:0]         rd_data_s;

  assign rd_data_s = mem[rd_ptr_q];

  // Next-state logic for the FIFO bookkeeping and the frame serializer.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    // Full is judged before this cycle's pop, so a push into a full FIFO is lost even if a pop happens.
    push_s    = bus.Wr_En & ~full_q;
    pop_s     = (state_q == S_IDLE) & ~empty_q;
    bit_end_s = (baud_q == BAUD_LAST);

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    full_d  = (count_d == DEPTH_L);
    empty_d = (count_d == LEVEL_0);
    ovf_d   = ovf_q | (bus.Wr_En & full_q);

    case (state_q)
      S_IDLE: begin
        baud_d = {BW{1'b0}};
        bit_d  = 3'd0;
        if (pop_s) begin
          shift_d = rd_data_s;
          par_d   = parity_bit(rd_data_s);
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end

      S_START: begin
        if (bit_end_s) begin
          baud_d  = {BW{1'b0}};
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end_s) begin
          baud_d = {BW{1'b0}};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
            if (PE_BIT) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // The line always shows shift_q[0]; shifting exposes the next data bit.
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (bit_end_s) begin
          baud_d  = {BW{1'b0}};
          state_d = S_STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end_s) begin
          baud_d = {BW{1'b0}};
          // bit_q counts completed stop-bit times here.
          if (bit_q == STOP_LAST) begin
            bit_d   = 3'd0;
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = {BW{1'b0}};
        bit_d   = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drives the line high at once and flushes the FIFO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      baud_q   <= {BW{1'b0}};
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= {FIFO_AW{1'b0}};
      rd_ptr_q <= {FIFO_AW{1'b0}};
      count_q  <= LEVEL_0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem[wr_ptr_q] <= bus.Wr_Data;
    end
  end

  assign bus.Full     = full_q;
  assign bus.Empty    = empty_q;
  assign bus.Level    = count_q;
  assign bus.Overflow = ovf_q;
  assign bus.Rs232_Tx = tx_q;
  assign bus.Tx_Busy  = busy_q;
  assign bus.Tx_Done  = done_q;

endmodule
